dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Initiator-side controller for one DSP48A1 slice configured as a multiply-accumulator.
- Accepts a start command plus a stream of A/B operand pairs over a valid/ready handshake, and drives the slice's operand, opmode and clock-enable inputs.
- Reads back P once the pipeline has drained and returns the dot product on a valid/ready result port.
- Sits between a data mover (upstream) and the DSP slice (downstream).

Parameters:
- LEN_W, 16, width of the sample-count command.
- MUL_LAT, 2, cycles from operand issue at dsp_a/dsp_b to product at the post-adder input (A1REG+B1REG stage + MREG); range 1..4.
- OPMODE_LAT, 1, opmode register depth inside the slice (OPMODEREG); range 0..1, must be <= MUL_LAT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_a  in  18  operand A.
- in_b  in  18  operand B.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice opmode.
- dsp_cep  out  1  to slice CEP.
- dsp_p  in  48  from slice P.
- busy  out  1  high outside IDLE.
- result  out  48  accumulated sum.
- result_valid  out  1  result held.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset values:
  - all outputs 0; dsp_opmode 8'h00; state IDLE.
  - Reset mid-operation abandons the job. Slice contents are don't-care because the next job starts with Z=0.
- States:
  - IDLE: on start with len!=0, latch len into remaining, go to RUN. On start with len==0, load result=0 and go to DONE.
  - RUN:
    - in_ready=1.
    - Handshake: fire = in_valid&&in_ready. On fire, dsp_a/dsp_b take in_a/in_b and remaining decrements.
    - On the fire with remaining==1, go to DRAIN.
    - Non-fire cycles are bubbles; dsp_a/dsp_b hold.
  - DRAIN: in_ready=0. Wait MUL_LAT+1 cycles for the last product to leave PREG, then capture result=dsp_p and go to DONE.
  - DONE: result_valid=1, result stable. On result_ready go to IDLE; start is ignored until then.
- Opmode and CEP alignment:
  - Each fire produces a tag {valid=1, first}, with first=1 for the first pair of the job; a bubble produces valid=0.
  - Tags travel a shift register. dsp_opmode is driven from tap MUL_LAT-OPMODE_LAT; dsp_cep is driven from tap MUL_LAT.
  - first=1 → opmode 8'h01 (X=M, Z=0, add, no pre-adder, carry 0).
  - first=0 → 8'h09 (X=M, Z=P).
  - Tag valid=0 → dsp_cep=0 so P holds through bubbles; opmode is don't-care, driven 8'h09.
- Arithmetic: 18x18 unsigned products accumulated mod 2^48 inside the slice. The sequencer performs no arithmetic other than the counter.
- Throughput: one pair per cycle. Job latency is len + MUL_LAT + 2 cycles from the first fire to result_valid, with no bubbles.
- Back-to-back jobs: a start in the same cycle DONE→IDLE is ignored; earliest accepted start is the following cycle.

Optional Feature:
- DSP_MAC_SEQ_OVF_EN:
  - When defined, adds port dsp_carryout (in, 1, from slice CARRYOUT, aligned with P) and output result_ovf (1).
  - result_ovf is a sticky OR of dsp_carryout on every cycle whose delayed tag had valid=1, one cycle after that CEP. It is cleared on job start and presented with result.
- When undefined, neither port exists and no overflow logic is built.

Decomposition:
- Package dsp_mac_seq_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - OPMODE_MAC_FIRST=8'h01;
  - OPMODE_MAC_ACC=8'h09;
  - tag struct {valid, first}.
- Sub-module dsp_tag_delay: a parameterised-depth shift register of tags with reset to valid=0, used for opmode and CEP taps.

Test Plan:
- len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back against a slice model → result=100 exactly 8 cycles after first fire; opmode sequence 01,09,09,09.
- len=3, pairs (10,10),(20,20),(30,30) with in_valid low for 2 cycles between pairs → result=1400; dsp_cep low in every bubble-aligned cycle.
- len=0 start → result_valid=1 next cycle with result=0; no dsp_cep pulse.
- Job of len=2 with 10 result_ready-low cycles in DONE, then a second job (2,3),(4,5) → first result held stable; second result=26 unaffected by the prior P.
- rst_n asserted mid-RUN after 2 of 5 pairs, then job len=1 (6,7) → all outputs 0 during reset; new result=42.
- With DSP_MAC_SEQ_OVF_EN, len=2, pairs (3FFFF,3FFFF) twice with P preloaded near 2^48 via a model forcing carry → result_ovf=1; a subsequent clean job → result_ovf=0.

Source files
------------

// File: rtl/dsp_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_seq_pkg
// Brief    : Shared types and opmode constants for the DSP48A1 MAC sequencer.
// Revision : 1.0
// ============================================================================
package dsp_mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] OPMODE_MAC_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPMODE_MAC_ACC   = 8'h09;  // X=M, Z=P

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

  function automatic logic [7:0] tag_opmode(input tag_t t);
    return (t.valid && t.first) ? OPMODE_MAC_FIRST : OPMODE_MAC_ACC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_mac_sequencer_tag_delay.sv
`default_nettype none
// ============================================================================
// Module   : dsp_tag_delay
// Brief    : Shift register of operand tags with two taps (tap 0 = input).
// Revision : 1.0
// ============================================================================
module dsp_tag_delay
  import dsp_mac_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAP_A = 1,
  parameter int TAP_B = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tap_a,
  output tag_t tap_b
);

  tag_t r_stage [1:DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[1] <= tag_in;
      for (int i = 2; i <= DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  generate
    if (TAP_A == 0) begin : g_tap_a_pass
      assign tap_a = tag_in;
    end else begin : g_tap_a_reg
      assign tap_a = r_stage[TAP_A];
    end
    if (TAP_B == 0) begin : g_tap_b_pass
      assign tap_b = tag_in;
    end else begin : g_tap_b_reg
      assign tap_b = r_stage[TAP_B];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Brief    : Streams A/B pairs into a DSP48A1 MAC and returns the dot product.
//            Optional overflow flag when DSP_MAC_SEQ_OVF_EN is defined.
// Revision : 1.0
// ============================================================================
module dsp_mac_sequencer
  import dsp_mac_seq_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int MUL_LAT    = 2,
  parameter int OPMODE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cep,
  input  logic [47:0]      dsp_p,
  output logic             busy,
  output logic [47:0]      result,
  output logic             result_valid,
  input  logic             result_ready
`ifdef DSP_MAC_SEQ_OVF_EN
  ,
  input  logic             dsp_carryout,
  output logic             result_ovf
`endif
);

  // Last product is in PREG after MUL_LAT+1 drain cycles; sample it one later.
  localparam logic [2:0] DRAIN_LAST = 3'(MUL_LAT + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_remaining;
  logic             r_first;
  logic [2:0]       r_drain;
  logic             w_fire;
  logic             w_accept;
  logic             w_zero_job;
  logic             w_capture;
  tag_t             w_tag_in;
  tag_t             w_op_tag;
  tag_t             w_cep_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_fire       = 1'b0;
    w_accept     = 1'b0;
    w_zero_job   = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_zero_job   = 1'b1;
            w_state_next = DONE;
          end else begin
            w_accept     = 1'b1;
            w_state_next = RUN;
          end
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_fire = 1'b1;
          if (r_remaining == LEN_W'(1)) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          w_capture    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (result_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy         = (r_state != IDLE);
  assign result_valid = (r_state == DONE);
  assign w_tag_in     = '{valid: w_fire, first: w_fire & r_first};

  // Output registers add one cycle, so the taps feeding them sit one stage early.
  dsp_tag_delay #(
    .DEPTH (MUL_LAT),
    .TAP_A (MUL_LAT - OPMODE_LAT),
    .TAP_B (MUL_LAT)
  ) u_tag_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (w_tag_in),
    .tap_a  (w_op_tag),
    .tap_b  (w_cep_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_drain     <= '0;
      dsp_a       <= '0;
      dsp_b       <= '0;
      dsp_opmode  <= 8'h00;
      dsp_cep     <= 1'b0;
      result      <= '0;
    end else begin
      if (w_accept) begin
        r_remaining <= len;
        r_first     <= 1'b1;
      end
      if (w_fire) begin
        dsp_a       <= in_a;
        dsp_b       <= in_b;
        r_remaining <= r_remaining - LEN_W'(1);
        r_first     <= 1'b0;
      end
      r_drain    <= (r_state == DRAIN) ? r_drain + 3'd1 : 3'd0;
      dsp_opmode <= tag_opmode(w_op_tag);
      dsp_cep    <= w_cep_tag.valid;
      if (w_zero_job)     result <= '0;
      else if (w_capture) result <= dsp_p;
    end
  end

`ifdef DSP_MAC_SEQ_OVF_EN
  logic r_cep_d;

  // CARRYOUT is aligned with P, i.e. valid the cycle after the CEP that loaded it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cep_d    <= 1'b0;
      result_ovf <= 1'b0;
    end else begin
      r_cep_d <= dsp_cep;
      if (w_accept || w_zero_job)      result_ovf <= 1'b0;
      else if (r_cep_d && dsp_carryout) result_ovf <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Brief    : Self-checking bench with a DSP48A1 MAC slice model (MUL_LAT=2,
//            OPMODEREG=1). Overflow checks built when DSP_MAC_SEQ_OVF_EN is set.
// Revision : 1.0
// ============================================================================
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a, in_b;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_cep;
  logic [47:0] dsp_p;
  logic        busy;
  logic [47:0] result;
  logic        result_valid;
  logic        result_ready;
`ifdef DSP_MAC_SEQ_OVF_EN
  logic        result_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_sequencer #(.LEN_W(16), .MUL_LAT(2), .OPMODE_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_cep      (dsp_cep),
    .dsp_p        (dsp_p),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
`ifdef DSP_MAC_SEQ_OVF_EN
    ,
    .dsp_carryout (carry),
    .result_ovf   (result_ovf)
`endif
  );

  // DSP48A1 slice model: A1/B1 regs, MREG, OPMODEREG, PREG gated by CEP.
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m = '0;
  logic [7:0]  opm_r = '0;
  logic [47:0] p = '0;
  logic        carry = 1'b0;
  logic        force_carry = 1'b0;
  logic [48:0] p_sum;

  assign p_sum = {1'b0, (opm_r[3:2] == 2'b10) ? p : 48'd0} + 49'(m);
  assign dsp_p = p;

  always @(posedge clk) begin
    a1    <= dsp_a;
    b1    <= dsp_b;
    m     <= a1 * b1;
    opm_r <= dsp_opmode;
    if (dsp_cep) begin
      p     <= p_sum[47:0];
      carry <= p_sum[48] | force_carry;
    end
  end

  // Opmode that the slice registered for each CEP cycle.
  logic [7:0] prev_op = '0;
  logic [7:0] cep_log[$];
  always @(negedge clk) begin
    if (dsp_cep) cep_log.push_back(prev_op);
    prev_op <= dsp_opmode;
  end

  logic [47:0] exp_q[$];

  typedef struct packed {
    logic [15:0]       len;
    logic [7:0][17:0]  a;
    logic [7:0][17:0]  b;
    int                gap;
    int                hold;
    logic [47:0]       exp;
    bit                lat;
    bit                ovf;
  } job_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    int n, gap_left, guard, fire_cyc, start_cyc, exp_cyc;
    logic [47:0] held, expv;
    bit stable;
    exp_q.push_back(j.exp);
    cep_log.delete();
    start = 1'b1; len = j.len; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0; gap_left = 0; guard = 0; fire_cyc = -1;
    while (n < int'(j.len) && guard < 200) begin
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else begin
        in_valid = 1'b1; in_a = j.a[n]; in_b = j.b[n];
        if (in_ready) begin
          if (n == 0) fire_cyc = cyc;
          n++;
          gap_left = j.gap;
        end
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (!result_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    expv = exp_q.pop_front();
    chk("result_valid", 128'(result_valid), 128'(1));
    if (j.lat) begin
      exp_cyc = (j.len == 0) ? start_cyc + 1 : fire_cyc + int'(j.len) + 4;
      chk("latency", 128'(cyc), 128'(exp_cyc));
    end
    chk("result", 128'(result), 128'(expv));
`ifdef DSP_MAC_SEQ_OVF_EN
    chk("result_ovf", 128'(result_ovf), 128'(j.ovf));
`endif
    chk("cep_count", 128'(cep_log.size()), 128'(j.len));
    foreach (cep_log[k])
      chk("opmode", 128'(cep_log[k]), 128'((k == 0) ? 8'h01 : 8'h09));
    held = result; stable = 1'b1;
    for (int k = 0; k < j.hold; k++) begin
      start = (k == 3);
      len   = 16'd5;
      @(negedge clk);
      if (!result_valid || result !== held || !busy) stable = 1'b0;
    end
    start = 1'b0;
    if (j.hold > 0) chk("hold_stable", 128'(stable), 128'(1));
    // Start in the DONE->IDLE cycle must be ignored.
    result_ready = 1'b1; start = 1'b1; len = 16'd3;
    @(negedge clk);
    result_ready = 1'b0; start = 1'b0;
    chk("released_idle", 128'({busy, result_valid}), 128'(0));
  endtask

  function automatic logic [127:0] outs_now();
    return 128'({in_ready, busy, result_valid, dsp_cep, dsp_opmode, dsp_a, dsp_b, result});
  endfunction

  job_t jobs[6];
  job_t jr;

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; result_ready = 1'b0;

    jobs[0] = '0; jobs[0].len = 4; jobs[0].exp = 48'd100; jobs[0].lat = 1'b1;
    jobs[0].a[0] = 1; jobs[0].b[0] = 2; jobs[0].a[1] = 3; jobs[0].b[1] = 4;
    jobs[0].a[2] = 5; jobs[0].b[2] = 6; jobs[0].a[3] = 7; jobs[0].b[3] = 8;
    jobs[1] = '0; jobs[1].len = 3; jobs[1].gap = 2; jobs[1].exp = 48'd1400;
    jobs[1].a[0] = 10; jobs[1].b[0] = 10; jobs[1].a[1] = 20; jobs[1].b[1] = 20;
    jobs[1].a[2] = 30; jobs[1].b[2] = 30;
    jobs[2] = '0; jobs[2].len = 0; jobs[2].exp = 48'd0; jobs[2].lat = 1'b1;
    jobs[3] = '0; jobs[3].len = 2; jobs[3].hold = 10; jobs[3].exp = 48'd140000;
    jobs[3].a[0] = 100; jobs[3].b[0] = 200; jobs[3].a[1] = 300; jobs[3].b[1] = 400;
    jobs[4] = '0; jobs[4].len = 2; jobs[4].exp = 48'd26; jobs[4].lat = 1'b1;
    jobs[4].a[0] = 2; jobs[4].b[0] = 3; jobs[4].a[1] = 4; jobs[4].b[1] = 5;
    jobs[5] = '0; jobs[5].len = 3; jobs[5].exp = 48'd206156857347; jobs[5].lat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      jobs[5].a[k] = 18'h3FFFF; jobs[5].b[k] = 18'h3FFFF;
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_now(), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Reset in the middle of a len=5 job after two pairs.
    start = 1'b1; len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_a = 18'(k + 1); in_b = 18'(k + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_run", outs_now(), 128'(0));
    @(negedge clk);
    chk("reset_held", outs_now(), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    jr = '0; jr.len = 1; jr.exp = 48'd42; jr.lat = 1'b1; jr.a[0] = 6; jr.b[0] = 7;
    run_job(jr);

`ifdef DSP_MAC_SEQ_OVF_EN
    force_carry = 1'b1;
    jr = '0; jr.len = 2; jr.exp = 48'd137437904898; jr.ovf = 1'b1;
    jr.a[0] = 18'h3FFFF; jr.b[0] = 18'h3FFFF; jr.a[1] = 18'h3FFFF; jr.b[1] = 18'h3FFFF;
    run_job(jr);
    force_carry = 1'b0;
    run_job(jobs[4]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
